cacheline_arbiter: RTL and testbench

- Sits between the split L1 instruction cache and L1 data cache and the single shared downstream port, the L2 cache, inside the mp3 top level.
- Accepts whole-cacheline read and write requests from both L1s and grants the downstream port to one requester at a time.
- Holds each grant until the downstream responds, then routes the response to the owner only.
- Is the only sequencing point for shared-memory traffic between the two L1s and the L2.

---
 rtl/arbiter_types_pkg.sv | 18 +
 rtl/arb_perf_counters.sv | 36 +++
 rtl/cacheline_arbiter.sv | 128 ++++++++++++
 tb/tb_cacheline_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_types_pkg.sv
// Shared types and constants for the L1 to L2 cacheline arbiter.
package arbiter_types_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    OWNER_I,
    OWNER_D
  } owner_t;

  localparam int LINE_BYTES  = 32;
  localparam int OFFSET_BITS = 5;

endpackage

// File: rtl/arb_perf_counters.sv
// Saturating 32-bit performance counters for the cacheline arbiter:
// grants completed per requester and IDLE cycles spent under contention.
// Only instantiated when ARB_PERF_COUNTERS_EN is defined.
module arb_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_done,
  input  logic        d_done,
  input  logic        contention,
  output logic [31:0] i_grant_count,
  output logic [31:0] d_grant_count,
  output logic [31:0] contention_count
);

  logic [31:0] i_cnt_q;
  logic [31:0] d_cnt_q;
  logic [31:0] c_cnt_q;

  // Each counter increments on its event and sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
      c_cnt_q <= '0;
    end else begin
      if (i_done && (i_cnt_q != '1)) i_cnt_q <= i_cnt_q + 32'd1;
      if (d_done && (d_cnt_q != '1)) d_cnt_q <= d_cnt_q + 32'd1;
      if (contention && (c_cnt_q != '1)) c_cnt_q <= c_cnt_q + 32'd1;
    end
  end

  assign i_grant_count    = i_cnt_q;
  assign d_grant_count    = d_cnt_q;
  assign contention_count = c_cnt_q;

endmodule

// File: rtl/cacheline_arbiter.sv
// Arbitrates whole-cacheline traffic from the L1 I-cache and L1 D-cache onto
// the single L2 port. One owner at a time, held until l2_resp; contention is
// resolved in favour of whoever did not get the previous grant.
// Optional counters: define ARB_PERF_COUNTERS_EN.
module cacheline_arbiter
  import arbiter_types_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_addr,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp
`ifdef ARB_PERF_COUNTERS_EN
  ,
  output logic [31:0]           i_grant_count,
  output logic [31:0]           d_grant_count,
  output logic [31:0]           contention_count
`endif
);

  arb_state_t state_q;
  owner_t     last_grant_q;
  logic       d_req;

  assign d_req = d_read | d_write;

  // Arbitration FSM: pick an owner in IDLE, hold it until the L2 completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= OWNER_D;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_read && d_req) begin
            state_q <= (last_grant_q == OWNER_D) ? SERVE_I : SERVE_D;
          end else if (i_read) begin
            state_q <= SERVE_I;
          end else if (d_req) begin
            state_q <= SERVE_D;
          end
        end
        SERVE_I: begin
          if (l2_resp) begin
            state_q      <= IDLE;
            last_grant_q <= OWNER_I;
          end
        end
        SERVE_D: begin
          if (l2_resp) begin
            state_q      <= IDLE;
            last_grant_q <= OWNER_D;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Route the owner's request to the L2 and the L2 completion back to the owner.
  always_comb begin
    l2_read  = 1'b0;
    l2_write = 1'b0;
    l2_addr  = '0;
    l2_wdata = '0;
    i_resp   = 1'b0;
    d_resp   = 1'b0;
    case (state_q)
      SERVE_I: begin
        l2_read = i_read;
        l2_addr = i_addr;
        i_resp  = l2_resp;
      end
      SERVE_D: begin
        l2_read  = d_read;
        l2_write = d_write;
        l2_addr  = d_addr;
        l2_wdata = d_wdata;
        d_resp   = l2_resp;
      end
      default: ;
    endcase
  end

  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

  // A D-cache request is either a read or a writeback, never both.
  assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));

  // Requests always name a whole, aligned cacheline.
  assert property (@(posedge clk) disable iff (!rst)
                   i_read |-> (i_addr[OFFSET_BITS-1:0] == '0));

`ifdef ARB_PERF_COUNTERS_EN
  logic contention;

  assign contention = (state_q == IDLE) && i_read && d_req;

  arb_perf_counters u_perf (
    .clk              (clk),
    .rst              (rst),
    .i_done           (i_resp),
    .d_done           (d_resp),
    .contention       (contention),
    .i_grant_count    (i_grant_count),
    .d_grant_count    (d_grant_count),
    .contention_count (contention_count)
  );
`endif

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed self-checking bench for cacheline_arbiter. Each request pushes its
// expected L2 transaction onto a scoreboard; the bench plays the L2 and pops
// the front entry when it completes a transaction.
module tb_cacheline_arbiter;

  logic         clk;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_addr;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         l2_read;
  logic         l2_write;
  logic [31:0]  l2_addr;
  logic [255:0] l2_wdata;
  logic [255:0] l2_rdata;
  logic         l2_resp;
`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0]  i_grant_count;
  logic [31:0]  d_grant_count;
  logic [31:0]  contention_count;
`endif

  typedef struct {
    logic         isD;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } txn_t;

  txn_t sb[$];
  int   checks;
  int   errors;
  int   iGrants;
  int   dGrants;
  logic lastGrantD;

  cacheline_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_read   (i_read),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_resp   (i_resp),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_resp   (d_resp),
    .l2_read  (l2_read),
    .l2_write (l2_write),
    .l2_addr  (l2_addr),
    .l2_wdata (l2_wdata),
    .l2_rdata (l2_rdata),
    .l2_resp  (l2_resp)
`ifdef ARB_PERF_COUNTERS_EN
    ,
    .i_grant_count    (i_grant_count),
    .d_grant_count    (d_grant_count),
    .contention_count (contention_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] lineFor(input logic [31:0] a);
    return {8{32'hA5A5A5A5}} ^ {8{a}};
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs,
                             input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic isD, input logic wr,
                               input logic [31:0] addr, input logic [255:0] wdata);
    txn_t t;
    t.isD   = isD;
    t.wr    = wr;
    t.addr  = addr;
    t.wdata = isD ? wdata : '0;
    if (isD) begin
      d_read  = ~wr;
      d_write = wr;
      d_addr  = addr;
      d_wdata = wdata;
    end else begin
      i_read = 1'b1;
      i_addr = addr;
    end
    sb.push_back(t);
  endtask

  // Owner is already granted; hold the L2 busy for waitCycles, then complete.
  task automatic serveFront(input int waitCycles);
    txn_t         t;
    logic [255:0] line;
    t = sb[0];
    for (int k = 0; k <= waitCycles; k++) begin
      checkOutput("l2_read", l2_read, !t.wr);
      checkOutput("l2_write", l2_write, t.wr);
      checkOutput("l2_addr", l2_addr, t.addr);
      checkOutput("l2_wdata", l2_wdata, t.wdata);
      checkOutput("i_resp_busy", i_resp, 1'b0);
      checkOutput("d_resp_busy", d_resp, 1'b0);
      if (k < waitCycles) waitCycle();
    end
    line     = lineFor(t.addr);
    l2_rdata = line;
    l2_resp  = 1'b1;
    #1;
    checkOutput("i_resp", i_resp, !t.isD);
    checkOutput("d_resp", d_resp, t.isD);
    checkOutput("owner_rdata", t.isD ? d_rdata : i_rdata, line);
    void'(sb.pop_front());
    if (t.isD) dGrants++;
    else iGrants++;
    lastGrantD = t.isD;
    waitCycle();
    l2_resp = 1'b0;
    if (t.isD) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
    #1;
    checkOutput("idle_l2_read", l2_read, 1'b0);
    checkOutput("idle_l2_write", l2_write, 1'b0);
    checkOutput("idle_l2_addr", l2_addr, '0);
  endtask

  task automatic contend(input logic [31:0] aI, input logic [31:0] aD);
    txn_t ti;
    txn_t td;
    ti = '{isD: 1'b0, wr: 1'b0, addr: aI, wdata: '0};
    td = '{isD: 1'b1, wr: 1'b0, addr: aD, wdata: '0};
    i_read  = 1'b1;
    i_addr  = aI;
    d_read  = 1'b1;
    d_write = 1'b0;
    d_addr  = aD;
    d_wdata = '0;
    if (lastGrantD) begin
      sb.push_back(ti);
      sb.push_back(td);
    end else begin
      sb.push_back(td);
      sb.push_back(ti);
    end
    waitCycle();
    serveFront(0);
    waitCycle();
    serveFront(0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    iGrants    = 0;
    dGrants    = 0;
    lastGrantD = 1'b1;
    rst        = 1'b0;
    i_read     = 1'b0;
    i_addr     = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    l2_rdata   = '0;
    l2_resp    = 1'b0;
    #12;
    checkOutput("rst_l2_read", l2_read, 1'b0);
    checkOutput("rst_l2_write", l2_write, 1'b0);
    checkOutput("rst_i_resp", i_resp, 1'b0);
    checkOutput("rst_d_resp", d_resp, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    waitCycle();

    $display("[TB] lone i_read");
    applyStimulus(1'b0, 1'b0, 32'h60, '0);
    #1;
    checkOutput("arb_latency", l2_read, 1'b0);
    waitCycle();
    serveFront(0);

    $display("[TB] lone d_write");
    applyStimulus(1'b1, 1'b1, 32'hC80, {8{32'hDEADBEEF}} ^ {8{32'h01234567}});
    waitCycle();
    serveFront(1);

    $display("[TB] i_read arriving during D service");
    waitCycle();
    applyStimulus(1'b1, 1'b0, 32'h1000, {8{32'h5A5A0F0F}});
    waitCycle();
    applyStimulus(1'b0, 1'b0, 32'h2040, '0);
    #1;
    serveFront(3);
    waitCycle();
    serveFront(0);

    $display("[TB] l2_resp in IDLE ignored");
    l2_rdata = {8{32'h13579BDF}};
    l2_resp  = 1'b1;
    #1;
    checkOutput("stray_i_resp", i_resp, 1'b0);
    checkOutput("stray_d_resp", d_resp, 1'b0);
    waitCycle();
    l2_resp = 1'b0;
    #1;
    checkOutput("stray_l2_read", l2_read, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h80, '0);
    waitCycle();
    serveFront(0);

    $display("[TB] async reset during SERVE_I");
    applyStimulus(1'b0, 1'b0, 32'h300, '0);
    waitCycle();
    checkOutput("pre_rst_l2_read", l2_read, 1'b1);
    l2_resp = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_l2_read", l2_read, 1'b0);
    checkOutput("async_l2_addr", l2_addr, '0);
    checkOutput("async_i_resp", i_resp, 1'b0);
    l2_resp = 1'b0;
    i_read  = 1'b0;
    sb.delete();
    lastGrantD = 1'b1;
    iGrants    = 0;
    dGrants    = 0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    waitCycle();
    checkOutput("post_rst_l2_read", l2_read, 1'b0);

    $display("[TB] contended rounds");
    contend(32'h400, 32'h800);
    contend(32'h420, 32'h820);
    contend(32'h440, 32'h840);

    $display("[TB] lone d_read after reset");
    applyStimulus(1'b1, 1'b0, 32'h440, '0);
    waitCycle();
    serveFront(0);

`ifdef ARB_PERF_COUNTERS_EN
    checkOutput("i_grant_count", i_grant_count, iGrants);
    checkOutput("d_grant_count", d_grant_count, dGrants);
    checks++;
    assert (contention_count >= 32'd3)
    else begin
      errors++;
      $error("[TB] FAIL contention_count observed=%0d expected>=3", contention_count);
    end
`endif

    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
